// File: rtl/clk_divider_prog_if.sv
// Command strobes and divided-clock status of the programmable divider.
// Strobes are single-cycle with no backpressure; outputs are registered.
interface clk_divider_prog_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 i_start_stb;
  logic                 i_step_stb;
  logic                 i_stop_stb;
  logic                 i_abort_stb;
  logic                 i_load_stb;
  logic [DIV_WIDTH-1:0] i_half_period;
  logic                 o_div_clk;
  logic                 o_div_clk_rose;
  logic                 o_div_clk_fell;
  logic                 o_running;
  logic [DIV_WIDTH-1:0] o_half_period;

  modport master (
    output i_start_stb, i_step_stb, i_stop_stb, i_abort_stb, i_load_stb, i_half_period,
    input  o_div_clk, o_div_clk_rose, o_div_clk_fell, o_running, o_half_period
  );

  modport slave (
    input  i_start_stb, i_step_stb, i_stop_stb, i_abort_stb, i_load_stb, i_half_period,
    output o_div_clk, o_div_clk_rose, o_div_clk_fell, o_running, o_half_period
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Run-time programmable divided clock (idle high) with run/step/stop/abort control.
// First edge H cycles after the accepting strobe; strobes never stall.
module clk_divider_prog #(
  parameter int                   DIV_WIDTH           = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_HALF_PERIOD = 16'd2604
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  clk_divider_prog_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STEP     = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] h_q, h_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 div_q, div_d;
  logic                 rose_q, rose_d;
  logic                 fell_q, fell_d;

  logic [DIV_WIDTH-1:0] load_val;
  logic [DIV_WIDTH-1:0] reload_h;
  logic                 cnt_zero;
  logic                 idle;

  // A same-cycle load wins over the stored pending value at any reload point.
  assign load_val = (bus.i_half_period == '0) ? DIV_WIDTH'(1) : bus.i_half_period;
  assign reload_h = bus.i_load_stb ? load_val : pend_q;
  assign cnt_zero = (cnt_q == '0);
  assign idle     = (state_q == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start_stb)     state_d = S_RUN;
        else if (bus.i_step_stb) state_d = S_STEP;
      end
      S_RUN: begin
        if (bus.i_abort_stb)     state_d = S_IDLE;
        else if (bus.i_stop_stb) state_d = S_STOPPING;
      end
      S_STEP: begin
        if (bus.i_abort_stb)           state_d = S_IDLE;
        else if (cnt_zero && !div_q)   state_d = S_IDLE;
      end
      S_STOPPING: begin
        if (bus.i_abort_stb || cnt_zero) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d = reload_h;
    h_d    = h_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    rose_d = 1'b0;
    fell_d = 1'b0;
    if (idle) begin
      if (bus.i_start_stb || bus.i_step_stb) begin
        h_d   = reload_h;
        cnt_d = reload_h - DIV_WIDTH'(1);
      end else begin
        h_d   = pend_q;
        cnt_d = pend_q - DIV_WIDTH'(1);
      end
    end else if (bus.i_abort_stb) begin
      div_d = 1'b1;
      cnt_d = h_q - DIV_WIDTH'(1);
    end else if (cnt_zero) begin
      h_d   = reload_h;
      cnt_d = reload_h - DIV_WIDTH'(1);
      // A stop that lands on the high phase ends without starting another low pulse.
      if ((state_q != S_STOPPING) || !div_q) begin
        div_d  = ~div_q;
        rose_d = ~div_q;
        fell_d = div_q;
      end
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q  <= DEFAULT_HALF_PERIOD - DIV_WIDTH'(1);
      h_q    <= DEFAULT_HALF_PERIOD;
      pend_q <= DEFAULT_HALF_PERIOD;
      div_q  <= 1'b1;
      rose_q <= 1'b0;
      fell_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      h_q    <= h_d;
      pend_q <= pend_d;
      div_q  <= div_d;
      rose_q <= rose_d;
      fell_q <= fell_d;
    end
  end

  assign bus.o_div_clk      = div_q;
  assign bus.o_div_clk_rose = rose_q;
  assign bus.o_div_clk_fell = fell_q;
  assign bus.o_running      = !idle;
  assign bus.o_half_period  = h_q;

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!(rose_q && fell_q));
      assert (!idle || div_q);
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: edge-time reference model plus literal checkpoints.
module tb_clk_divider_prog;
  localparam int DEF = 2604;
  localparam logic [4:0] M_LOAD  = 5'b00001;
  localparam logic [4:0] M_START = 5'b00010;
  localparam logic [4:0] M_STEP  = 5'b00100;
  localparam logic [4:0] M_STOP  = 5'b01000;
  localparam logic [4:0] M_ABORT = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stb = 1'b0, step_stb = 1'b0, stop_stb = 1'b0, abort_stb = 1'b0, load_stb = 1'b0;
  logic [15:0] hp = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_divider_prog_if #(.DIV_WIDTH(16)) bus ();

  assign bus.i_start_stb   = start_stb;
  assign bus.i_step_stb    = step_stb;
  assign bus.i_stop_stb    = stop_stb;
  assign bus.i_abort_stb   = abort_stb;
  assign bus.i_load_stb    = load_stb;
  assign bus.i_half_period = hp;

  clk_divider_prog #(.DIV_WIDTH(16), .DEFAULT_HALF_PERIOD(16'd2604)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the absolute edge index of the next half-period end.
  // States: 0 idle, 1 run, 2 single step, 3 stopping.
  int cyc = 0;
  int m_state = 0;
  int m_h = DEF, m_pend = DEF, m_nxt = 0;
  bit m_clk = 1'b1, m_rose = 1'b0, m_fell = 1'b0;

  always @(posedge clk) begin
    int ld;
    int old_pend;
    bit at_end;
    cyc++;
    ld = load_stb ? ((hp == 16'd0) ? 1 : int'(hp)) : m_pend;
    old_pend = m_pend;
    m_rose = 1'b0;
    m_fell = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_clk = 1'b1; m_h = DEF; m_pend = DEF;
    end else begin
      m_pend = ld;
      at_end = (m_state != 0) && (cyc == m_nxt);
      if (m_state == 0) begin
        if (start_stb || step_stb) begin
          m_state = start_stb ? 1 : 2;
          m_h = ld;
          m_nxt = cyc + ld;
        end else begin
          m_h = old_pend;
        end
      end else if (abort_stb) begin
        m_state = 0;
        m_clk = 1'b1;
      end else if (at_end) begin
        m_h = ld;
        m_nxt = cyc + ld;
        if (m_state == 3) begin
          if (!m_clk) begin m_clk = 1'b1; m_rose = 1'b1; end
          m_state = 0;
        end else begin
          m_clk = !m_clk;
          m_rose = m_clk;
          m_fell = !m_clk;
          if (m_state == 2 && m_clk) m_state = 0;
          else if (m_state == 1 && stop_stb) m_state = 3;
        end
      end else if (m_state == 1 && stop_stb) begin
        m_state = 3;
      end
    end
  end

  always @(negedge clk) begin
    check("model_div_clk",  int'(bus.o_div_clk),      int'(m_clk));
    check("model_rose",     int'(bus.o_div_clk_rose), int'(m_rose));
    check("model_fell",     int'(bus.o_div_clk_fell), int'(m_fell));
    check("model_running",  int'(bus.o_running),      (m_state != 0) ? 1 : 0);
    check("model_half",     int'(bus.o_half_period),  m_h);
  end

  // Call at a negedge: strobes are sampled at the next posedge; returns at the negedge after it.
  task automatic pulse(input logic [4:0] m, input logic [15:0] v);
    load_stb  = m[0];
    start_stb = m[1];
    step_stb  = m[2];
    stop_stb  = m[3];
    abort_stb = m[4];
    hp = v;
    @(negedge clk);
    {load_stb, start_stb, step_stb, stop_stb, abort_stb} = 5'b0;
    hp = 16'd0;
  endtask

  initial begin
    // Reset with strobes held
    rst_n = 1'b0; start_stb = 1'b1; step_stb = 1'b1; load_stb = 1'b1; hp = 16'd5;
    repeat (3) @(negedge clk);
    check("rst_div_clk", int'(bus.o_div_clk), 1);
    check("rst_running", int'(bus.o_running), 0);
    check("rst_half",    int'(bus.o_half_period), 2604);
    check("rst_rose",    int'(bus.o_div_clk_rose), 0);
    rst_n = 1'b1; start_stb = 1'b0; step_stb = 1'b0; load_stb = 1'b0; hp = 16'd0;
    @(negedge clk);
    check("post_rst_running", int'(bus.o_running), 0);

    // H=3 free run
    pulse(M_LOAD, 16'd3);
    @(negedge clk);
    check("idle_load_half", int'(bus.o_half_period), 3);
    pulse(M_START, 16'd0);
    check("run_e0_div", int'(bus.o_div_clk), 1);
    check("run_e0_running", int'(bus.o_running), 1);
    repeat (2) @(negedge clk);
    check("run_e2_div", int'(bus.o_div_clk), 1);
    @(negedge clk);
    check("run_e3_div", int'(bus.o_div_clk), 0);
    check("run_e3_fell", int'(bus.o_div_clk_fell), 1);
    repeat (3) @(negedge clk);
    check("run_e6_div", int'(bus.o_div_clk), 1);
    check("run_e6_rose", int'(bus.o_div_clk_rose), 1);
    repeat (3) @(negedge clk);
    check("run_e9_div", int'(bus.o_div_clk), 0);
    pulse(M_ABORT, 16'd0);
    check("abort_div", int'(bus.o_div_clk), 1);
    check("abort_rose", int'(bus.o_div_clk_rose), 0);
    check("abort_running", int'(bus.o_running), 0);

    // H=3 single step
    pulse(M_STEP, 16'd0);
    check("step_e0_running", int'(bus.o_running), 1);
    repeat (3) @(negedge clk);
    check("step_e3_div", int'(bus.o_div_clk), 0);
    check("step_e3_fell", int'(bus.o_div_clk_fell), 1);
    repeat (3) @(negedge clk);
    check("step_e6_div", int'(bus.o_div_clk), 1);
    check("step_e6_rose", int'(bus.o_div_clk_rose), 1);
    check("step_e6_running", int'(bus.o_running), 0);
    repeat (20) @(negedge clk);
    check("step_quiet_div", int'(bus.o_div_clk), 1);

    // H=4 graceful stop during low phase
    pulse(M_LOAD, 16'd4);
    @(negedge clk);
    check("load4_half", int'(bus.o_half_period), 4);
    pulse(M_START, 16'd0);
    repeat (5) @(negedge clk);
    pulse(M_STOP, 16'd0);
    check("stop_lo_e6_div", int'(bus.o_div_clk), 0);
    check("stop_lo_e6_running", int'(bus.o_running), 1);
    @(negedge clk);
    check("stop_lo_e7_div", int'(bus.o_div_clk), 0);
    @(negedge clk);
    check("stop_lo_e8_div", int'(bus.o_div_clk), 1);
    check("stop_lo_e8_rose", int'(bus.o_div_clk_rose), 1);
    check("stop_lo_e8_running", int'(bus.o_running), 0);

    // Stop during high phase
    pulse(M_START, 16'd0);
    @(negedge clk);
    pulse(M_STOP, 16'd0);
    @(negedge clk);
    check("stop_hi_e3_running", int'(bus.o_running), 1);
    @(negedge clk);
    check("stop_hi_e4_div", int'(bus.o_div_clk), 1);
    check("stop_hi_e4_fell", int'(bus.o_div_clk_fell), 0);
    check("stop_hi_e4_running", int'(bus.o_running), 0);

    // H=5 with a mid-phase load of 2, then load 0
    pulse(M_LOAD, 16'd5);
    @(negedge clk);
    pulse(M_START, 16'd0);
    repeat (2) @(negedge clk);
    pulse(M_LOAD, 16'd2);
    check("ld_e3_half", int'(bus.o_half_period), 5);
    repeat (2) @(negedge clk);
    check("ld_e5_div", int'(bus.o_div_clk), 0);
    check("ld_e5_half", int'(bus.o_half_period), 2);
    repeat (2) @(negedge clk);
    check("ld_e7_rose", int'(bus.o_div_clk_rose), 1);
    repeat (2) @(negedge clk);
    check("ld_e9_div", int'(bus.o_div_clk), 0);
    pulse(M_LOAD, 16'd0);
    check("ld0_e10_half", int'(bus.o_half_period), 2);
    @(negedge clk);
    check("ld0_e11_div", int'(bus.o_div_clk), 1);
    check("ld0_e11_half", int'(bus.o_half_period), 1);
    @(negedge clk);
    check("ld0_e12_fell", int'(bus.o_div_clk_fell), 1);
    @(negedge clk);
    check("ld0_e13_div", int'(bus.o_div_clk), 1);
    @(negedge clk);
    check("ld0_e14_div", int'(bus.o_div_clk), 0);

    // Reset mid-run while low, strobes held
    rst_n = 1'b0; start_stb = 1'b1; step_stb = 1'b1; stop_stb = 1'b1; load_stb = 1'b1; hp = 16'd7;
    @(negedge clk);
    check("mrst_div", int'(bus.o_div_clk), 1);
    check("mrst_running", int'(bus.o_running), 0);
    check("mrst_half", int'(bus.o_half_period), 2604);
    @(negedge clk);
    rst_n = 1'b1; start_stb = 1'b0; step_stb = 1'b0; stop_stb = 1'b0; load_stb = 1'b0; hp = 16'd0;
    @(negedge clk);
    check("mrst_after_running", int'(bus.o_running), 0);
    check("mrst_after_half", int'(bus.o_half_period), 2604);

    // Start and step together -> free run
    pulse(M_LOAD, 16'd2);
    @(negedge clk);
    pulse(M_START | M_STEP, 16'd0);
    repeat (2) @(negedge clk);
    check("ss_e2_div", int'(bus.o_div_clk), 0);
    repeat (2) @(negedge clk);
    check("ss_e4_div", int'(bus.o_div_clk), 1);
    repeat (4) @(negedge clk);
    check("ss_e8_running", int'(bus.o_running), 1);
    pulse(M_ABORT, 16'd0);
    check("ss_abort_running", int'(bus.o_running), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable successor to the fixed-rate clock divider.
- Generates a divided clock (idle level high) from i_clk. Half-period is loadable at run time without glitches.
- Supports free-run, single-step (exactly one full divided cycle) and graceful stop (no runt pulses), plus an immediate abort.
- Drives Z80/peripheral clock enables. Rose/fell strobes are provided for logic kept in the i_clk domain.

Parameters:
- DIV_WIDTH, 16, width of the half-period counter and of the load value.
- DEFAULT_HALF_PERIOD, 16'd2604, half-period in i_clk cycles after reset.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_start_stb  in  1  1-cycle strobe; starts free-run from IDLE.
- i_step_stb  in  1  1-cycle strobe; emits exactly one low+high divided cycle from IDLE.
- i_stop_stb  in  1  1-cycle strobe; graceful stop at the end of the current half-period.
- i_abort_stb  in  1  1-cycle strobe; immediate return to IDLE.
- i_load_stb  in  1  1-cycle strobe; captures i_half_period.
- i_half_period  in  DIV_WIDTH  new half-period H in i_clk cycles.
- o_div_clk  out  1  divided clock, registered.
- o_div_clk_rose  out  1  high for the one cycle in which o_div_clk has just become 1.
- o_div_clk_fell  out  1  high for the one cycle in which o_div_clk has just become 0.
- o_running  out  1  high in RUN, STEP or STOPPING.
- o_half_period  out  DIV_WIDTH  currently active H (readback).

Behaviour:
- Reset (i_reset_n=0 at a posedge):
  - o_div_clk=1, rose=0, fell=0, o_running=0.
  - state=IDLE; active H and pending H = DEFAULT_HALF_PERIOD; counter = H-1.
  - All strobes are ignored during reset.
- Load:
  - On i_load_stb, pending H <= i_half_period, with 0 clamped to 1.
  - Pending H becomes active only at a reload point: a start/step acceptance, or a counter==0 toggle.
  - Load in the same cycle as a reload point: the new value is used for that reload.
  - o_half_period shows the active H.
- Counter:
  - Down-counter over H-1..0; decrements only in RUN/STEP/STOPPING; otherwise held at active H-1.
  - In IDLE, a pending load updates active H and the counter on the next cycle.
- Toggle:
  - When the counter is 0 in an active state: o_div_clk inverts on the next edge (subject to the STOPPING rule below) and the counter reloads to H-1.
  - Rose/fell are registered in the same edge as the o_div_clk change.
- Timing:
  - Strobe sampled at edge 0: the state becomes active after edge 0, with counter = H-1.
  - First fall is after edge H; first rise after edge 2H.
  - Period is 2H i_clk cycles, 50% duty. H=1 gives i_clk/2.
- FSM states: IDLE, RUN, STEP, STOPPING.
  - IDLE -> RUN on start.
  - IDLE -> STEP on step, if start is not also present.
  - RUN -> STOPPING on stop.
  - STEP -> IDLE after the rising toggle (o_div_clk back to 1).
  - STOPPING, at counter==0:
    - if o_div_clk=0: toggle to 1 (rose pulses), then -> IDLE.
    - if o_div_clk=1: no toggle (no fell pulse), -> IDLE.
  - Any active state -> IDLE on abort: o_div_clk forced to 1 next edge with no rose pulse; counter reloads.
- Priority for simultaneous strobes: reset > abort > stop > start > step.
  - Start in RUN/STEP/STOPPING is ignored.
  - Step outside IDLE is ignored.
  - Stop in IDLE or STEP is ignored.
  - Abort in IDLE is a no-op.
- Invariants:
  - In IDLE, o_div_clk=1.
  - Rose and fell are never high together.
  - No o_div_clk pulse shorter than min(old H, new H) except on abort.

Test Plan:
- H=3, start at edge 0 -> o_div_clk 1 until edge 3, 0 after edges 3–5, 1 after edge 6; fell at cycle after edge 3, rose after edge 6; period 6 repeating; o_running=1.
- H=3, step at edge 0 -> single low phase after edges 3–5, high after edge 6, o_running falls after edge 6; no further toggles over 20 cycles.
- RUN H=4, stop while o_div_clk=0 with counter=2 -> rise after 3 more edges, then IDLE with o_div_clk=1; stop while high -> IDLE at the next counter==0 with no fell pulse.
- RUN H=5, load 2 mid-half-period -> current half-period completes at 5 cycles, subsequent half-periods 2 cycles; o_half_period=2 from that reload; load 0 -> H=1 (toggle every cycle).
- RUN low phase, abort -> o_div_clk=1 next cycle, rose=0, o_running=0; start and step in the same cycle from IDLE -> RUN (free-run continues beyond one cycle).
- Reset asserted mid-RUN with o_div_clk=0 -> after edge: o_div_clk=1, IDLE, o_half_period=2604; strobes held during reset have no effect.
